// File: rtl/axil_slave_regbank.sv
// axil_slave_regbank
// AXI4-Lite responder backed by a bank of DEPTH 32-bit words.
// Write and read channels are independent. Responses are registered one
// cycle after the final address/data handshake. Addresses outside the bank
// return SLVERR and do not touch storage.
//
// Ports
//   clk, reset                       clock, asynchronous active-high reset
//   awaddr/awvalid/awready           write address channel
//   wdata/wstrb/wvalid/wready        write data channel
//   bresp/bvalid/bready              write response channel
//   araddr/arvalid/arready           read address channel
//   rdata/rresp/rvalid/rready        read data channel
module axil_slave_regbank #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9,
    parameter int DEPTH      = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [ADDR_WIDTH-1:0]     awaddr,
    input  logic                      awvalid,
    output logic                      awready,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic [DATA_WIDTH/8-1:0]   wstrb,
    input  logic                      wvalid,
    output logic                      wready,
    output logic [1:0]                bresp,
    output logic                      bvalid,
    input  logic                      bready,
    input  logic [ADDR_WIDTH-1:0]     araddr,
    input  logic                      arvalid,
    output logic                      arready,
    output logic [DATA_WIDTH-1:0]     rdata,
    output logic [1:0]                rresp,
    output logic                      rvalid,
    input  logic                      rready
);

    localparam int IDX_W  = ADDR_WIDTH - 2;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LANES  = DATA_WIDTH / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] W_IDLE      = 2'd0;
    localparam logic [1:0] W_HAVE_ADDR = 2'd1;
    localparam logic [1:0] W_HAVE_DATA = 2'd2;
    localparam logic [1:0] W_RESP      = 2'd3;

    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    // Byte-offset bits carry no meaning: accesses are word-granular.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = &{1'b0, awaddr[1:0], araddr[1:0]};

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    logic [1:0]              w_state_reg, w_state_next;
    logic [IDX_W-1:0]        aw_word_reg;
    logic [DATA_WIDTH-1:0]   w_data_reg;
    logic [LANES-1:0]        w_strb_reg;
    logic [1:0]              bresp_reg;

    logic                    aw_hs, w_hs;
    logic                    commit;
    logic [IDX_W-1:0]        commit_word;
    logic [DATA_WIDTH-1:0]   commit_data;
    logic [LANES-1:0]        commit_strb;
    logic                    commit_in_range;
    logic [MEM_AW-1:0]       commit_idx;

    // Ready is a pure function of registered state, never of valid.
    assign awready = (w_state_reg == W_IDLE) || (w_state_reg == W_HAVE_DATA);
    assign wready  = (w_state_reg == W_IDLE) || (w_state_reg == W_HAVE_ADDR);
    assign bvalid  = (w_state_reg == W_RESP);
    assign bresp   = bresp_reg;

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;

    // Commit operands come from the live bus for whichever half arrives on
    // the final handshake and from the holding registers for the other.
    always_comb begin
        w_state_next = w_state_reg;
        commit       = 1'b0;
        commit_word  = aw_word_reg;
        commit_data  = w_data_reg;
        commit_strb  = w_strb_reg;
        case (w_state_reg)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    w_state_next = W_RESP;
                    commit       = 1'b1;
                    commit_word  = awaddr[ADDR_WIDTH-1:2];
                    commit_data  = wdata;
                    commit_strb  = wstrb;
                end else if (aw_hs) begin
                    w_state_next = W_HAVE_ADDR;
                end else if (w_hs) begin
                    w_state_next = W_HAVE_DATA;
                end
            end
            W_HAVE_ADDR: begin
                if (w_hs) begin
                    w_state_next = W_RESP;
                    commit       = 1'b1;
                    commit_data  = wdata;
                    commit_strb  = wstrb;
                end
            end
            W_HAVE_DATA: begin
                if (aw_hs) begin
                    w_state_next = W_RESP;
                    commit       = 1'b1;
                    commit_word  = awaddr[ADDR_WIDTH-1:2];
                end
            end
            default: begin
                if (bready) begin
                    w_state_next = W_IDLE;
                end
            end
        endcase
    end

    assign commit_in_range = (32'(commit_word) < DEPTH);
    assign commit_idx      = commit_word[MEM_AW-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_state_reg <= W_IDLE;
            aw_word_reg <= '0;
            w_data_reg  <= '0;
            w_strb_reg  <= '0;
            bresp_reg   <= RESP_OKAY;
        end else begin
            w_state_reg <= w_state_next;
            if (aw_hs) begin
                aw_word_reg <= awaddr[ADDR_WIDTH-1:2];
            end
            if (w_hs) begin
                w_data_reg <= wdata;
                w_strb_reg <= wstrb;
            end
            if (commit) begin
                bresp_reg <= commit_in_range ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    // One register per word so the whole bank clears on reset.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    mem[gi] <= '0;
                end else if (commit && commit_in_range &&
                             (commit_idx == MEM_AW'(gi))) begin
                    for (int b = 0; b < LANES; b++) begin
                        if (commit_strb[b]) begin
                            mem[gi][8*b +: 8] <= commit_data[8*b +: 8];
                        end
                    end
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    logic [0:0]            r_state_reg, r_state_next;
    logic [DATA_WIDTH-1:0] rdata_reg;
    logic [1:0]            rresp_reg;
    logic                  ar_hs;
    logic [IDX_W-1:0]      ar_word;
    logic                  ar_in_range;

    assign arready = (r_state_reg == R_IDLE);
    assign rvalid  = (r_state_reg == R_DATA);
    assign rdata   = rdata_reg;
    assign rresp   = rresp_reg;

    assign ar_hs       = arvalid && arready;
    assign ar_word     = araddr[ADDR_WIDTH-1:2];
    assign ar_in_range = (32'(ar_word) < DEPTH);

    always_comb begin
        r_state_next = r_state_reg;
        if (r_state_reg == R_IDLE) begin
            if (ar_hs) begin
                r_state_next = R_DATA;
            end
        end else if (rready) begin
            r_state_next = R_IDLE;
        end
    end

    // Sampling mem with a non-blocking update in flight means a read that
    // lands on the same edge as a write commit sees the old word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state_reg <= R_IDLE;
            rdata_reg   <= '0;
            rresp_reg   <= RESP_OKAY;
        end else begin
            r_state_reg <= r_state_next;
            if (ar_hs) begin
                if (ar_in_range) begin
                    rdata_reg <= mem[ar_word[MEM_AW-1:0]];
                    rresp_reg <= RESP_OKAY;
                end else begin
                    rdata_reg <= '0;
                    rresp_reg <= RESP_SLVERR;
                end
            end
        end
    end

endmodule

// File: tb/tb_axil_slave_regbank.sv
// Directed bench for axil_slave_regbank: expected responses are queued when a
// transaction is issued and compared when the response channel delivers it.
module tb_axil_slave_regbank;

    logic        clk = 1'b0;
    logic        reset;
    logic [8:0]  awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [8:0]  araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    axil_slave_regbank #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(9),
        .DEPTH(64)
    ) dut (
        .clk(clk),
        .reset(reset),
        .awaddr(awaddr),
        .awvalid(awvalid),
        .awready(awready),
        .wdata(wdata),
        .wstrb(wstrb),
        .wvalid(wvalid),
        .wready(wready),
        .bresp(bresp),
        .bvalid(bvalid),
        .bready(bready),
        .araddr(araddr),
        .arvalid(arvalid),
        .arready(arready),
        .rdata(rdata),
        .rresp(rresp),
        .rvalid(rvalid),
        .rready(rready)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    logic [1:0]  b_queue [$];
    logic [33:0] r_queue [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Called #1 after the edge of the final request handshake.
    task automatic finish_b(input string tag);
        logic [1:0] e;
        e = (b_queue.size() != 0) ? b_queue.pop_front() : 2'bxx;
        check({tag, "_bvalid_latency"}, 64'(bvalid), 64'd1);
        check({tag, "_bresp"}, 64'(bresp), 64'(e));
        $display("write %s: bresp=%b expected=%b", tag, bresp, e);
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        check({tag, "_bvalid_drop"}, 64'(bvalid), 64'd0);
    endtask

    task automatic finish_r(input string tag);
        logic [33:0] e;
        e = (r_queue.size() != 0) ? r_queue.pop_front() : 34'bx;
        check({tag, "_rvalid_latency"}, 64'(rvalid), 64'd1);
        check({tag, "_rresp_rdata"}, 64'({rresp, rdata}), 64'(e));
        $display("read %s: rresp=%b rdata=%h expected=%b/%h", tag, rresp, rdata, e[33:32], e[31:0]);
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        check({tag, "_rvalid_drop"}, 64'(rvalid), 64'd0);
    endtask

    task automatic write_same(input string tag, input logic [8:0] a, input logic [31:0] d,
                              input logic [3:0] s, input logic [1:0] resp);
        @(negedge clk);
        check({tag, "_aw_w_ready"}, 64'({awready, wready}), 64'b11);
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        b_queue.push_back(resp);
        finish_b(tag);
    endtask

    task automatic read(input string tag, input logic [8:0] a, input logic [31:0] d,
                        input logic [1:0] resp);
        @(negedge clk);
        check({tag, "_arready"}, 64'(arready), 64'd1);
        araddr = a; arvalid = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0;
        r_queue.push_back({resp, d});
        finish_r(tag);
    endtask

    initial begin
        reset = 1'b1;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b0; araddr = '0; arvalid = 1'b0; rready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_valids", 64'({bvalid, rvalid}), 64'b00);
        check("reset_readys", 64'({awready, wready, arready}), 64'b111);
        check("reset_resps_rdata", 64'({bresp, rresp, rdata}), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("post_reset_readys", 64'({awready, wready, arready, bvalid, rvalid}), 64'b11100);

        // Aligned write then read
        write_same("wr_010", 9'h010, 32'hCAFEBABE, 4'hF, 2'b00);
        read("rd_010", 9'h010, 32'hCAFEBABE, 2'b00);

        // Staggered: W first, AW three cycles later; a second W while
        // wready is low must be ignored.
        write_same("wr_020_init", 9'h020, 32'hAABBCCDD, 4'hF, 2'b00);
        @(negedge clk);
        wdata = 32'h11223344; wstrb = 4'b0101; wvalid = 1'b1;
        @(posedge clk); #1;
        wdata = 32'hFFFFFFFF; wstrb = 4'hF;
        check("have_data_readys", 64'({awready, wready}), 64'b10);
        repeat (2) @(posedge clk);
        @(negedge clk);
        awaddr = 9'h020; awvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        b_queue.push_back(2'b00);
        finish_b("wr_020_stagger");
        read("rd_020", 9'h020, 32'hAA22CC44, 2'b00);

        // Out of range
        write_same("wr_100_oor", 9'h100, 32'h12345678, 4'hF, 2'b10);
        read("rd_1fc_oor", 9'h1FC, 32'h0, 2'b10);
        read("rd_000_untouched", 9'h000, 32'h0, 2'b00);

        // Backpressure on both response channels
        @(negedge clk);
        awaddr = 9'h030; wdata = 32'h00000055; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        araddr = 9'h010; arvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        b_queue.push_back(2'b00);
        r_queue.push_back({2'b00, 32'hCAFEBABE});
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall_cycle%0d", i),
                  64'({bvalid, bresp, rvalid, rresp, rdata, awready, wready, arready}),
                  64'({1'b1, 2'b00, 1'b1, 2'b00, 32'hCAFEBABE, 3'b000}));
            @(posedge clk); #1;
        end
        finish_b("wr_030_stall");
        finish_r("rd_010_stall");
        read("rd_030", 9'h030, 32'h00000055, 2'b00);

        // Same-edge read and write commit to one word
        write_same("wr_040_init", 9'h040, 32'h1, 4'hF, 2'b00);
        @(negedge clk);
        awaddr = 9'h040; wdata = 32'h2; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 9'h040; arvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        b_queue.push_back(2'b00);
        r_queue.push_back({2'b00, 32'h1});
        finish_b("wr_040_collide");
        finish_r("rd_040_collide");
        read("rd_040_after", 9'h040, 32'h2, 2'b00);

        // Reset in the middle of a write
        write_same("wr_050_init", 9'h050, 32'hDEADBEEF, 4'hF, 2'b00);
        @(negedge clk);
        awaddr = 9'h050; awvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0;
        check("have_addr_readys", 64'({awready, wready}), 64'b01);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("async_reset_state", 64'({awready, wready, bvalid}), 64'b110);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check("post_midreset_state", 64'({awready, wready, bvalid, rvalid}), 64'b1100);
        read("rd_050_cleared", 9'h050, 32'h0, 2'b00);
        read("rd_010_cleared", 9'h010, 32'h0, 2'b00);

        check("b_queue_drained", 64'(b_queue.size()), 64'd0);
        check("r_queue_drained", 64'(r_queue.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/axil_slave_regbank.md
Name: axil_slave_regbank

Overview:
- AXI4-Lite responder (slave) with a word-addressed register bank of DEPTH 32-bit words.
- It is the other end of the master-side AXI-Lite interface: it answers write and read transactions that the master wrapper issues on that interface.
- It allows a bench or SoC to terminate the master interface with a checkable storage target and error responses.

Parameters:
- DATA_WIDTH, 32, data bus width; fixed at 32 (4 byte lanes).
- ADDR_WIDTH, 9, byte address width.
- DEPTH, 64, number of words; valid byte addresses are 0 to 4*DEPTH-1; must satisfy 4*DEPTH <= 2^ADDR_WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- awaddr  in  ADDR_WIDTH  write byte address.
- awvalid  in  1  write address valid.
- awready  out  1  write address ready.
- wdata  in  32  write data.
- wstrb  in  4  write byte strobes.
- wvalid  in  1  write data valid.
- wready  out  1  write data ready.
- bresp  out  2  write response: 00 OKAY, 10 SLVERR.
- bvalid  out  1  write response valid.
- bready  in  1  write response ready.
- araddr  in  ADDR_WIDTH  read byte address.
- arvalid  in  1  read address valid.
- arready  out  1  read address ready.
- rdata  out  32  read data.
- rresp  out  2  read response.
- rvalid  out  1  read data valid.
- rready  in  1  read data ready.

Behaviour:
- Reset (async, active-high):
  - Write FSM goes to W_IDLE; read FSM goes to R_IDLE.
  - All storage words clear to 0.
  - bvalid=0, rvalid=0, bresp=00, rresp=00, rdata=0.
  - awready, wready and arready follow the reset states (all 1).
  - Reset mid-transaction abandons it: no storage update and no response is issued after reset releases.
- Addressing:
  - Word index = addr[ADDR_WIDTH-1:2]; addr[1:0] is ignored (no unaligned handling).
  - An address is in range when index < DEPTH.
- Write FSM states: W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP.
  - awready=1 in W_IDLE and W_HAVE_DATA; wready=1 in W_IDLE and W_HAVE_ADDR. Both are decoded from registered state only and never depend on valid inputs.
  - W_IDLE: AW and W handshakes in the same cycle -> W_RESP. AW only -> latch address, go to W_HAVE_ADDR. W only -> latch data and strobes, go to W_HAVE_DATA.
  - W_HAVE_ADDR: W handshake -> W_RESP. W_HAVE_DATA: AW handshake -> W_RESP.
  - Commit happens on the transition into W_RESP, at the same edge bvalid rises:
    - In range: each byte lane with wstrb[i]=1 is written; lanes with wstrb=0 keep their value; bresp=00.
    - Out of range: no storage change; bresp=10.
  - wstrb=0000 in range is legal: no change, bresp=00.
  - W_RESP: bvalid=1 with bresp held stable until bready. On handshake -> W_IDLE and bvalid=0 the next cycle.
  - Latency: bvalid is asserted 1 cycle after the final AW/W handshake.
  - Throughput: at most one write per 2 cycles with bready held high.
- Read FSM states: R_IDLE, R_DATA.
  - arready=1 only in R_IDLE.
  - AR handshake -> R_DATA. rdata and rresp are registered at that edge from the address.
    - In range: storage word, rresp=00.
    - Out of range: rdata=0, rresp=10.
  - R_DATA: rvalid=1 with rdata/rresp held stable until rready. On handshake -> R_IDLE.
  - Latency: rvalid is asserted 1 cycle after the AR handshake.
  - Throughput: one read per 2 cycles.
- Simultaneous events:
  - Read and write channels are fully independent and may be active in the same cycle.
  - If an AR handshake and a write commit to the same word land on the same edge, the read returns the pre-write value.
  - A read accepted on any later edge returns the new value.
- Stability rules:
  - Outputs never change while valid=1 and ready=0 on any response channel.
  - Inputs presented while the corresponding ready=0 are ignored.

Test Plan:
- Aligned write, then read: AW+W at 0x010 with data 0xCAFEBABE and wstrb=1111 in the same cycle -> bvalid in the next cycle with bresp=00. Read of 0x010 -> rvalid 1 cycle after AR, rdata=0xCAFEBABE, rresp=00.
- Staggered channels: W first (0x11223344, wstrb=0101), AW 0x020 three cycles later, word previously 0xAABBCCDD -> bvalid 1 cycle after AW. Readback = 0xAA22CC44.
- Out of range: write to 0x100 with DEPTH=64 -> bresp=10, storage unchanged. Read of 0x1FC -> rdata=0, rresp=10.
- Backpressure: hold bready=0 and rready=0 for 5 cycles -> bvalid, rvalid, bresp, rresp and rdata stay stable. awready and arready stay 0 until the respective response handshake completes.
- Same-edge collision: word 0x040 holds 0x1. Write of 0x2 commits on the same edge as the AR handshake for 0x040 -> rdata=0x1. A second read -> 0x2.
- Reset mid-write: AW accepted, reset pulsed before W -> after release bvalid=0, state is W_IDLE, and a read of that address returns 0.
